// File: rtl/axi_sub_sram_rmw.sv
// Memory-side AXI subordinate endpoint onto a word-wide single-port SRAM without byte enables.
// Partial-strobe writes run a read-modify-write sequence while hld stalls the upstream transfer.
module axi_sub_sram_rmw #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   MEM_DEPTH = 256,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  localparam int unsigned  BC        = DW / 8,
  localparam int unsigned  BW        = $clog2(BC),
  localparam int unsigned  MW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dv,
  input  logic [AW-1:0] addr,
  input  logic          write,
  input  logic [DW-1:0] wdata,
  input  logic [BC-1:0] wstrb,
  input  logic          last,
  output logic          hld,
  output logic [DW-1:0] rdata,
  output logic          rd_err,
  output logic          wr_err,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [MW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] WIN_BYTES = AW'(MEM_DEPTH * BC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rd_err_q, rd_err_d;
  logic [DW-1:0] merge_q, merge_d;

  logic [AW-1:0] off;
  logic [MW-1:0] idx;
  logic          in_range;
  logic          full;
  logic          none;
  logic          partial;

  // Burst framing carries no meaning for a single-word memory endpoint.
  logic unused_last;
  assign unused_last = last;

  // Address decode; the subtraction wraps so addresses below the base fall out of range.
  always_comb begin
    off      = addr - BASE_ADDR;
    in_range = (off < WIN_BYTES);
    idx      = off[BW +: MW];
    full     = &wstrb;
    none     = ~|wstrb;
    partial  = !full && !none;
  end

  // Merge new strobed bytes over the word returned by the RMW read.
  always_comb begin
    merge_d = merge_q;
    if (state_q == RMW_RD) begin
      for (int b = 0; b < int'(BC); b++) begin
        merge_d[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : mem_rdata[8*b +: 8];
      end
    end
  end

  // Next-state and combinational handshake / SRAM control.
  always_comb begin
    state_d   = state_q;
    rd_err_d  = 1'b0;
    hld       = 1'b0;
    wr_err    = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = idx;
    mem_wdata = wdata;

    unique case (state_q)
      IDLE: begin
        if (dv) begin
          if (!write) begin
            mem_cs   = in_range;
            rd_err_d = !in_range;
          end else if (!in_range || none) begin
            wr_err = !in_range;
          end else if (full) begin
            mem_cs = 1'b1;
            mem_we = 1'b1;
          end else if (partial) begin
            hld     = 1'b1;
            mem_cs  = 1'b1;
            state_d = RMW_RD;
          end
        end
      end
      RMW_RD: begin
        hld     = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merge_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_err_q <= 1'b0;
      merge_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_err_q <= rd_err_d;
      merge_q  <= merge_d;
    end
  end

  // Read return: SRAM data passes straight through; an out-of-range read returns zero.
  assign rdata  = rd_err_q ? '0 : mem_rdata;
  assign rd_err = rd_err_q;

  a_no_write_in_rmw_rd: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RMW_RD) |-> !(mem_cs && mem_we));

  a_dv_held_in_rmw: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> dv);

endmodule

// File: tb/tb_axi_sub_sram_rmw.sv
// Directed bench for axi_sub_sram_rmw with a behavioural single-port SRAM and hand-computed expectations.
module tb_axi_sub_sram_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv;
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        last;
  logic        hld;
  logic [31:0] rdata;
  logic        rd_err;
  logic        wr_err;
  logic        mem_cs;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] sram [256];
  int          wr_cnt = 0;
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          wr_snap;

  always #5 clk = ~clk;

  axi_sub_sram_rmw #(
    .AW(32), .DW(32), .MEM_DEPTH(256), .BASE_ADDR(32'h4000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dv(dv), .addr(addr), .write(write),
    .wdata(wdata), .wstrb(wstrb), .last(last), .hld(hld), .rdata(rdata),
    .rd_err(rd_err), .wr_err(wr_err), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port SRAM: read data appears the cycle after a read select.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        sram[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s);
    dv    = v;
    addr  = a;
    write = w;
    wdata = d;
    wstrb = s;
    last  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #12;
    check_eq("rst_hld", 32'(hld), 32'd0);
    check_eq("rst_cs", 32'(mem_cs), 32'd0);
    check_eq("rst_wr_err", 32'(wr_err), 32'd0);
    check_eq("rst_rd_err", 32'(rd_err), 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Full write then read back
    drive(1'b1, 32'h4010, 1'b1, 32'hDEADBEEF, 4'hF);
    #1;
    check_eq("fw_hld", 32'(hld), 32'd0);
    check_eq("fw_cs_we", 32'({mem_cs, mem_we}), 32'd3);
    check_eq("fw_addr", 32'(mem_addr), 32'd4);
    check_eq("fw_wdata", mem_wdata, 32'hDEADBEEF);
    check_eq("fw_wr_err", 32'(wr_err), 32'd0);
    tick();
    drive(1'b1, 32'h4010, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("rd_hld", 32'(hld), 32'd0);
    check_eq("rd_cs_we", 32'({mem_cs, mem_we}), 32'd2);
    check_eq("rd_addr", 32'(mem_addr), 32'd4);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("rd_rdata", rdata, 32'hDEADBEEF);
    check_eq("rd_rd_err", 32'(rd_err), 32'd0);

    // Partial write: preload word 4, then RMW bytes 3..2
    drive(1'b1, 32'h4010, 1'b1, 32'h11223344, 4'hF);
    tick();
    drive(1'b1, 32'h4012, 1'b1, 32'hAABBCCDD, 4'b1100);
    #1;
    check_eq("pw1_hld", 32'(hld), 32'd1);
    check_eq("pw1_cs_we", 32'({mem_cs, mem_we}), 32'd2);
    check_eq("pw1_addr", 32'(mem_addr), 32'd4);
    tick();
    check_eq("pw2_hld", 32'(hld), 32'd1);
    check_eq("pw2_cs", 32'(mem_cs), 32'd0);
    tick();
    check_eq("pw3_hld", 32'(hld), 32'd0);
    check_eq("pw3_cs_we", 32'({mem_cs, mem_we}), 32'd3);
    check_eq("pw3_addr", 32'(mem_addr), 32'd4);
    check_eq("pw3_wdata", mem_wdata, 32'hAABB3344);
    check_eq("pw3_wr_err", 32'(wr_err), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("pw_sram4", sram[4], 32'hAABB3344);

    // Out-of-range read above the window
    drive(1'b1, 32'h4400, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("oor_rd_cs", 32'(mem_cs), 32'd0);
    check_eq("oor_rd_hld", 32'(hld), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("oor_rdata", rdata, 32'h0);
    check_eq("oor_rd_err", 32'(rd_err), 32'd1);
    tick();
    check_eq("rd_err_pulse", 32'(rd_err), 32'd0);

    // Out-of-range write below the base (wraps)
    wr_snap = wr_cnt;
    drive(1'b1, 32'h3FFC, 1'b1, 32'h12345678, 4'hF);
    #1;
    check_eq("oor_wr_err", 32'(wr_err), 32'd1);
    check_eq("oor_wr_hld", 32'(hld), 32'd0);
    check_eq("oor_wr_cs", 32'(mem_cs), 32'd0);
    tick();

    // Zero-strobe write
    drive(1'b1, 32'h4020, 1'b1, 32'h87654321, 4'h0);
    #1;
    check_eq("zs_hld", 32'(hld), 32'd0);
    check_eq("zs_cs", 32'(mem_cs), 32'd0);
    check_eq("zs_wr_err", 32'(wr_err), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("no_sram_writes", 32'(wr_cnt), 32'(wr_snap));

    // Back-to-back: read, full write, read of the new word
    drive(1'b1, 32'h4000, 1'b1, 32'h01020304, 4'hF);
    tick();
    drive(1'b1, 32'h4000, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("b2b_r0_cs_we", 32'({mem_cs, mem_we}), 32'd2);
    check_eq("b2b_r0_hld", 32'(hld), 32'd0);
    tick();
    drive(1'b1, 32'h4004, 1'b1, 32'hCAFEF00D, 4'hF);
    #1;
    check_eq("b2b_r0_rdata", rdata, 32'h01020304);
    check_eq("b2b_w_hld", 32'(hld), 32'd0);
    check_eq("b2b_w_addr", 32'(mem_addr), 32'd1);
    check_eq("b2b_w_cs_we", 32'({mem_cs, mem_we}), 32'd3);
    tick();
    drive(1'b1, 32'h4004, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("b2b_r1_hld", 32'(hld), 32'd0);
    check_eq("b2b_r1_addr", 32'(mem_addr), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("b2b_r1_rdata", rdata, 32'hCAFEF00D);
    check_eq("b2b_r1_rd_err", 32'(rd_err), 32'd0);

    // Reset asserted during RMW_RD of a partial write
    drive(1'b1, 32'h4008, 1'b1, 32'h77777777, 4'hF);
    tick();
    wr_snap = wr_cnt;
    drive(1'b1, 32'h4008, 1'b1, 32'h00000055, 4'b0001);
    #1;
    check_eq("rr_hld1", 32'(hld), 32'd1);
    tick();
    check_eq("rr_in_rmw_rd_hld", 32'(hld), 32'd1);
    check_eq("rr_in_rmw_rd_cs", 32'(mem_cs), 32'd0);
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("rr_rst_hld", 32'(hld), 32'd0);
    check_eq("rr_rst_cs", 32'(mem_cs), 32'd0);
    check_eq("rr_rst_rd_err", 32'(rd_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rr_no_write", 32'(wr_cnt), 32'(wr_snap));
    check_eq("rr_sram2", sram[2], 32'h77777777);
    drive(1'b1, 32'h4008, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("rr_idle_hld", 32'(hld), 32'd0);
    check_eq("rr_idle_cs_we", 32'({mem_cs, mem_we}), 32'd2);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    check_eq("rr_rdata", rdata, 32'h77777777);
    check_eq("rr_rd_err", 32'(rd_err), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
